// File: rtl/arty_s7_pkg.sv
// -----------------------------------------------------------------------------
// arty_s7_pkg
// Helpers shared by the Arty S7 board-support blocks.
//   SYNC_STAGES   number of flip-flops in each pad synchroniser
//   ms_to_cycles  converts a duration in milliseconds into clk cycles
// -----------------------------------------------------------------------------
package arty_s7_pkg;

  localparam int SYNC_STAGES = 2;

  // The division comes first so that large clock rates stay inside 32 bits.
  function automatic int ms_to_cycles(input int freq, input int ms);
    return (freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/arty_s7_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// arty_s7_input_conditioner_if
// Bundles the pad inputs and the conditioned outputs of one input bank.
//   pin_i    raw pad levels, asynchronous to clk
//   level_o  debounced level
//   rise_o   1-cycle pulse when level_o goes 0->1
//   fall_o   1-cycle pulse when level_o goes 1->0
//   hold_o   1-cycle pulse when a press reaches the long-press threshold
//   held_o   high from hold_o until the level drops
// Modports:
//   master  the side that owns the pads and consumes the conditioned events
//   slave   the conditioner itself
// -----------------------------------------------------------------------------
interface arty_s7_input_conditioner_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0] pin_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] fall_o;
  logic [N_CH-1:0] hold_o;
  logic [N_CH-1:0] held_o;

  modport master (
    output pin_i,
    input  level_o,
    input  rise_o,
    input  fall_o,
    input  hold_o,
    input  held_o
  );

  modport slave (
    input  pin_i,
    output level_o,
    output rise_o,
    output fall_o,
    output hold_o,
    output held_o
  );

endinterface

// File: rtl/arty_s7_debounce_ch.sv
// -----------------------------------------------------------------------------
// arty_s7_debounce_ch
// One input channel: pad synchroniser, counter debounce, edge pulses and
// long-press detection. Every output comes straight from a flip-flop.
// Parameters:
//   DB_CYC    cycles the synchronised input must differ from the current level
//             before the level follows it (>= 2)
//   HOLD_CYC  cycles the level must stay high before hold fires (> DB_CYC)
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active low
//   i_pin    raw pad level, asynchronous to clk
//   o_level  debounced level
//   o_rise   1-cycle pulse on a committed 0->1 change
//   o_fall   1-cycle pulse on a committed 1->0 change
//   o_hold   1-cycle pulse when the level has been high for HOLD_CYC cycles
//   o_held   high from o_hold until the level drops
// -----------------------------------------------------------------------------
module arty_s7_debounce_ch
  import arty_s7_pkg::*;
#(
  parameter int DB_CYC   = 4,
  parameter int HOLD_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_hold,
  output logic o_held
);

  localparam int CNT_W  = $clog2(DB_CYC + 1);
  localparam int HCNT_W = $clog2(HOLD_CYC + 1);

  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYC - 1);
  localparam logic [HCNT_W-1:0] HOLD_MAX  = HCNT_W'(HOLD_CYC);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYC - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [HCNT_W-1:0]      r_hcnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_hold;
  logic                   r_held;

  logic w_sync;
  logic w_commit;
  logic w_drop;

  // Only the last synchroniser stage is allowed to feed any logic.
  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_commit = (w_sync != r_level) && (r_cnt == DB_LAST);
  // A committed release must clear the hold state on the very edge that
  // raises o_fall, while the registered level still reads 1.
  assign w_drop   = w_commit && !w_sync;

  // ---- synchroniser ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end
  end

  // ---- debounce: any sample equal to the current level restarts the window ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (w_commit) begin
        r_level <= w_sync;
        r_cnt   <= '0;
        r_rise  <= w_sync;
        r_fall  <= !w_sync;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // ---- long press: counts from the rise cycle and saturates at HOLD_CYC ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcnt <= '0;
      r_hold <= 1'b0;
      r_held <= 1'b0;
    end else begin
      r_hold <= 1'b0;
      if (!r_level || w_drop) begin
        r_hcnt <= '0;
        r_held <= 1'b0;
      end else if (r_hcnt < HOLD_MAX) begin
        r_hcnt <= r_hcnt + HCNT_W'(1);
        // Saturation guarantees this fires once per press.
        if (r_hcnt == HOLD_LAST) begin
          r_hold <= 1'b1;
          r_held <= 1'b1;
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_hold  = r_hold;
  assign o_held  = r_held;

endmodule

// File: rtl/arty_s7_input_conditioner.sv
// -----------------------------------------------------------------------------
// arty_s7_input_conditioner
// Conditions a bank of raw switch or button pads before user logic: each
// channel is synchronised, debounced and turned into level, edge and
// long-press events. Channels are fully independent.
// Parameters:
//   CLK_FREQ     clk frequency in Hz
//   N_CH         number of channels
//   DEBOUNCE_MS  debounce window in ms
//   HOLD_MS      long-press threshold in ms
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active low
//   io   arty_s7_input_conditioner_if.slave (pin_i in; level_o, rise_o,
//        fall_o, hold_o, held_o out, all N_CH wide)
// -----------------------------------------------------------------------------
module arty_s7_input_conditioner
  import arty_s7_pkg::*;
#(
  parameter int CLK_FREQ    = 12000000,
  parameter int N_CH        = 4,
  parameter int DEBOUNCE_MS = 10,
  parameter int HOLD_MS     = 1000
) (
  input logic                        clk,
  input logic                        rst,
  arty_s7_input_conditioner_if.slave io
);

  localparam int DB_CYC   = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int HOLD_CYC = ms_to_cycles(CLK_FREQ, HOLD_MS);

  // Elaboration-time sanity checks; they generate no hardware.
  initial begin
    if (N_CH < 1)
      $error("arty_s7_input_conditioner: N_CH must be at least 1");
    if (DB_CYC < 2)
      $error("arty_s7_input_conditioner: debounce window must be at least 2 cycles");
    if (HOLD_CYC <= DB_CYC)
      $error("arty_s7_input_conditioner: hold threshold must exceed debounce window");
  end

  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;
  logic [N_CH-1:0] w_hold;
  logic [N_CH-1:0] w_held;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    arty_s7_debounce_ch #(
      .DB_CYC   (DB_CYC),
      .HOLD_CYC (HOLD_CYC)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_pin   (io.pin_i[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g]),
      .o_hold  (w_hold[g]),
      .o_held  (w_held[g])
    );
  end

  assign io.level_o = w_level;
  assign io.rise_o  = w_rise;
  assign io.fall_o  = w_fall;
  assign io.hold_o  = w_hold;
  assign io.held_o  = w_held;

endmodule

// File: tb/tb_arty_s7_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_arty_s7_input_conditioner
// Directed bench for arty_s7_input_conditioner with DB_CYC=4, HOLD_CYC=20.
// A clean pin change becomes visible on level_o 6 clock edges after it is
// applied; hold_o follows 20 edges after rise_o.
// -----------------------------------------------------------------------------
module tb_arty_s7_input_conditioner;

  localparam int N_CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  arty_s7_input_conditioner_if #(.N_CH(N_CH)) u_if ();

  arty_s7_input_conditioner #(
    .CLK_FREQ    (4000),
    .N_CH        (N_CH),
    .DEBOUNCE_MS (1),
    .HOLD_MS     (5)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .io  (u_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] pin;
    int         ticks;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] hold;
    logic [3:0] held;
  } vec_t;

  vec_t vecs[$];

  // Outputs are sampled and inputs driven 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] l, input logic [3:0] r,
                         input logic [3:0] f, input logic [3:0] h, input logic [3:0] hd);
    chk({name, ".level"}, u_if.level_o, l);
    chk({name, ".rise"},  u_if.rise_o,  r);
    chk({name, ".fall"},  u_if.fall_o,  f);
    chk({name, ".hold"},  u_if.hold_o,  h);
    chk({name, ".held"},  u_if.held_o,  hd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int cnt;
    bit found;
    logic prev_held;

    u_if.pin_i = 4'h0;
    rst        = 1'b0;
    #1;

    // Reset held: toggling pins must not reach any output.
    for (int i = 0; i < 6; i++) begin
      u_if.pin_i = (i % 2 == 0) ? 4'hF : 4'h5;
      tick();
      chk_all($sformatf("rst_hold%0d", i), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    u_if.pin_i = 4'h0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk_all("rst_release", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    //            pin   ticks lvl   rise  fall  hold  held
    // clean press / release on ch0
    vecs.push_back('{4'h1, 5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h1, 1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h1, 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    // bounce on ch1: high 3, low 1, then steady
    vecs.push_back('{4'h2, 3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h2, 5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h2, 1, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 5, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0});
    // isolated 3-cycle glitch on ch1
    vecs.push_back('{4'h2, 3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    // all channels together, then 0 and 3 release
    vecs.push_back('{4'hF, 5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h6, 5, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h6, 1, 4'h6, 4'h0, 4'h9, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 6, 4'h0, 4'h0, 4'h6, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    // short 10-cycle press on ch2: no hold
    vecs.push_back('{4'h4, 6, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h4, 4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 6, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 20, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      u_if.pin_i = vecs[i].pin;
      repeat (vecs[i].ticks) tick();
      chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].rise, vecs[i].fall,
              vecs[i].hold, vecs[i].held);
    end

    // Long press on ch2.
    u_if.pin_i = 4'h4;
    t = 0; found = 1'b0;
    while (t < 20 && !found) begin
      tick(); t++;
      if (u_if.rise_o[2]) found = 1'b1;
    end
    chk_i("lp_rise_latency", t, 6);
    t = 0; found = 1'b0;
    while (t < 40 && !found) begin
      tick(); t++;
      if (u_if.hold_o[2]) found = 1'b1;
    end
    chk_i("lp_hold_latency", t, 20);
    chk("lp_held_at_hold", u_if.held_o, 4'h4);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (u_if.hold_o[2] || !u_if.held_o[2]) cnt++;
    end
    chk_i("lp_single_hold_held_steady", cnt, 0);
    u_if.pin_i = 4'h0;
    t = 0; found = 1'b0; prev_held = 1'b0;
    while (t < 20 && !found) begin
      prev_held = u_if.held_o[2];
      tick(); t++;
      if (u_if.fall_o[2]) found = 1'b1;
    end
    chk_i("lp_fall_latency", t, 6);
    chk_i("lp_held_before_fall", int'(prev_held), 1);
    chk_all("lp_fall_cycle", 4'h0, 4'h0, 4'h4, 4'h0, 4'h0);
    repeat (3) tick();

    // Reset two cycles before an expected rise on ch3.
    u_if.pin_i = 4'h8;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk_all("rst_mid_async", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (3) tick();
    chk_all("rst_mid_held", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b1;
    repeat (5) tick();
    chk_all("rst_rel_pre", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    chk_all("rst_rel_rise", 4'h8, 4'h8, 4'h0, 4'h0, 4'h0);

    // Reset in the middle of a hold count: the count must start over.
    repeat (15) tick();
    chk_all("rsth_pre", 4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    #1;
    chk_all("rsth_async", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (6) tick();
    chk_all("rsth_rise", 4'h8, 4'h8, 4'h0, 4'h0, 4'h0);
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (u_if.hold_o != 4'h0) cnt++;
    end
    chk_i("rsth_no_stale_hold", cnt, 0);
    tick();
    chk_all("rsth_hold", 4'h8, 4'h0, 4'h0, 4'h8, 4'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
